// File: rtl/tlb_pkg.sv
// Shared constants for the JTLB: entry field layout, CP0 op encodings and probe format.
package tlb_pkg;

  localparam int ENTRY_W = 80;
  localparam int VPN2_W  = 19;
  localparam int PFN_W   = 24;

  localparam int ASID_HI = 79;
  localparam int ASID_LO = 72;
  localparam int G_BIT   = 71;
  localparam int VPN2_HI = 70;
  localparam int VPN2_LO = 52;
  localparam int PFN1_HI = 51;
  localparam int PFN1_LO = 28;
  localparam int D1_BIT  = 27;
  localparam int V1_BIT  = 26;
  localparam int PFN0_HI = 25;
  localparam int PFN0_LO = 2;
  localparam int D0_BIT  = 1;
  localparam int V0_BIT  = 0;

  localparam int PROBE_MISS_BIT = 31;

  typedef enum logic [2:0] {
    TLB_OP_NOP = 3'd0,
    TLB_OP_WI  = 3'd1,
    TLB_OP_WR  = 3'd2,
    TLB_OP_P   = 3'd3,
    TLB_OP_R   = 3'd4
  } tlb_op_e;

  // Only the low 20 PFN bits reach the 32-bit physical address.
  function automatic logic [31:0] tlb_paddr(input logic [19:0] pfn, input logic [11:0] offs);
    return {pfn, offs};
  endfunction

endpackage

// File: rtl/tlb_array_if.sv
// Bus between the MMU front-end / CP0 (master) and the JTLB (slave).
interface tlb_array_if
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 8
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ASID_W-1:0]  asid;
  logic               i_req;
  logic [31:0]        i_vaddr;
  logic               i_rdy;
  logic [31:0]        i_paddr;
  logic               i_miss;
  logic               i_v;
  logic               d_req;
  logic [31:0]        d_vaddr;
  logic               d_rdy;
  logic [31:0]        d_paddr;
  logic               d_miss;
  logic               d_v;
  logic               d_dirty;
  logic [2:0]         op;
  logic [IDX_W-1:0]   op_index;
  logic [ENTRY_W-1:0] op_entry;
  logic               op_done;
  logic [ENTRY_W-1:0] rd_entry;
  logic [31:0]        probe;
  logic               wired_we;
  logic [IDX_W-1:0]   wired_in;
  logic [IDX_W-1:0]   random;
  logic               multi_hit;

  modport master (
    output asid, i_req, i_vaddr, d_req, d_vaddr, op, op_index, op_entry, wired_we, wired_in,
    input  i_rdy, i_paddr, i_miss, i_v, d_rdy, d_paddr, d_miss, d_v, d_dirty,
           op_done, rd_entry, probe, random, multi_hit
  );

  modport slave (
    input  asid, i_req, i_vaddr, d_req, d_vaddr, op, op_index, op_entry, wired_we, wired_in,
    output i_rdy, i_paddr, i_miss, i_v, d_rdy, d_paddr, d_miss, d_v, d_dirty,
           op_done, rd_entry, probe, random, multi_hit
  );

endinterface

// File: rtl/tlb_match.sv
// Combinational tag compare across all entries with lowest-index priority and multi-hit detect.
module tlb_match
  import tlb_pkg::*;
#(
  parameter int  ENTRIES = 16,
  parameter int  ASID_W  = 8,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]             i_present,
  input  logic [ENTRIES-1:0][VPN2_W-1:0] i_tag_vpn2,
  input  logic [ENTRIES-1:0]             i_tag_g,
  input  logic [ENTRIES-1:0][ASID_W-1:0] i_tag_asid,
  input  logic [VPN2_W-1:0]              i_vpn2,
  input  logic [ASID_W-1:0]              i_asid,
  output logic                           o_hit,
  output logic [IDX_W-1:0]               o_idx,
  output logic                           o_multi
);

  logic [ENTRIES-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_match[k] = i_present[k] && (i_tag_vpn2[k] == i_vpn2) &&
                   (i_tag_g[k] || (i_tag_asid[k] == i_asid));
    end
  end

  always_comb begin
    o_idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (w_match[k]) o_idx = IDX_W'(k);
    end
  end

  assign o_hit = |w_match;
  // Clearing the lowest set bit leaves something only if two or more matched.
  assign o_multi = |(w_match & (w_match - ENTRIES'(1)));

endmodule

// File: rtl/tlb_array.sv
// MIPS32-style JTLB: internal entry storage, registered I/D translation ports and CP0 TLB ops.
module tlb_array
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 8
) (
  input logic        clk,
  input logic        rst_n,
  tlb_array_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(ENTRIES - 1);

  logic [ENTRY_W-1:0] r_entry [ENTRIES];
  logic [ENTRIES-1:0] r_present;
  logic [IDX_W-1:0]   r_wired;
  logic [IDX_W-1:0]   r_random;

  logic               r_i_rdy, r_i_miss, r_i_v;
  logic [31:0]        r_i_paddr;
  logic               r_d_rdy, r_d_miss, r_d_v, r_d_dirty;
  logic [31:0]        r_d_paddr;
  logic               r_op_done;
  logic [ENTRY_W-1:0] r_rd_entry;
  logic [31:0]        r_probe;
  logic               r_multi;

  logic [ENTRIES-1:0][VPN2_W-1:0] w_tag_vpn2;
  logic [ENTRIES-1:0]             w_tag_g;
  logic [ENTRIES-1:0][ASID_W-1:0] w_tag_asid;

  always_comb begin
    w_tag_vpn2 = '0;
    w_tag_g    = '0;
    w_tag_asid = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      w_tag_vpn2[k] = r_entry[k][VPN2_HI:VPN2_LO];
      w_tag_g[k]    = r_entry[k][G_BIT];
      w_tag_asid[k] = r_entry[k][ASID_LO +: ASID_W];
    end
  end

  logic             w_i_hit, w_i_multi, w_d_hit, w_d_multi, w_p_hit, w_p_multi;
  logic [IDX_W-1:0] w_i_idx, w_d_idx, w_p_idx;

  tlb_match #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) u_match_i (
    .i_present(r_present), .i_tag_vpn2(w_tag_vpn2), .i_tag_g(w_tag_g), .i_tag_asid(w_tag_asid),
    .i_vpn2(bus.i_vaddr[31:13]), .i_asid(bus.asid),
    .o_hit(w_i_hit), .o_idx(w_i_idx), .o_multi(w_i_multi)
  );

  tlb_match #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) u_match_d (
    .i_present(r_present), .i_tag_vpn2(w_tag_vpn2), .i_tag_g(w_tag_g), .i_tag_asid(w_tag_asid),
    .i_vpn2(bus.d_vaddr[31:13]), .i_asid(bus.asid),
    .o_hit(w_d_hit), .o_idx(w_d_idx), .o_multi(w_d_multi)
  );

  tlb_match #(.ENTRIES(ENTRIES), .ASID_W(ASID_W)) u_match_p (
    .i_present(r_present), .i_tag_vpn2(w_tag_vpn2), .i_tag_g(w_tag_g), .i_tag_asid(w_tag_asid),
    .i_vpn2(bus.op_entry[VPN2_HI:VPN2_LO]), .i_asid(bus.op_entry[ASID_LO +: ASID_W]),
    .o_hit(w_p_hit), .o_idx(w_p_idx), .o_multi(w_p_multi)
  );

  logic               w_is_wi, w_is_wr, w_is_p, w_is_r, w_we;
  logic [IDX_W-1:0]   w_widx;
  logic [ENTRY_W-1:0] w_i_ent, w_d_ent;

  assign w_is_wi = (bus.op == TLB_OP_WI);
  assign w_is_wr = (bus.op == TLB_OP_WR);
  assign w_is_p  = (bus.op == TLB_OP_P);
  assign w_is_r  = (bus.op == TLB_OP_R);
  assign w_we    = w_is_wi || w_is_wr;
  assign w_widx  = w_is_wr ? r_random : bus.op_index;
  assign w_i_ent = r_entry[w_i_idx];
  assign w_d_ent = r_entry[w_d_idx];

  // Payload has no reset; the present bits alone keep stale storage from matching.
  always_ff @(posedge clk) begin
    if (w_we) r_entry[w_widx] <= bus.op_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_present <= '0;
      r_wired   <= '0;
      r_random  <= RAND_MAX;
    end else begin
      if (w_we) r_present[w_widx] <= 1'b1;
      if (bus.wired_we) begin
        r_wired  <= bus.wired_in;
        r_random <= RAND_MAX;
      end else if (r_wired >= RAND_MAX || r_random <= r_wired) begin
        r_random <= RAND_MAX;
      end else begin
        r_random <= r_random - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_rdy   <= 1'b0;
      r_i_miss  <= 1'b0;
      r_i_v     <= 1'b0;
      r_i_paddr <= '0;
      r_d_rdy   <= 1'b0;
      r_d_miss  <= 1'b0;
      r_d_v     <= 1'b0;
      r_d_dirty <= 1'b0;
      r_d_paddr <= '0;
    end else begin
      r_i_rdy <= bus.i_req;
      if (bus.i_req) begin
        r_i_miss <= !w_i_hit;
        if (!w_i_hit) begin
          r_i_paddr <= '0;
          r_i_v     <= 1'b0;
        end else if (bus.i_vaddr[12]) begin
          r_i_paddr <= tlb_paddr(w_i_ent[PFN1_LO +: 20], bus.i_vaddr[11:0]);
          r_i_v     <= w_i_ent[V1_BIT];
        end else begin
          r_i_paddr <= tlb_paddr(w_i_ent[PFN0_LO +: 20], bus.i_vaddr[11:0]);
          r_i_v     <= w_i_ent[V0_BIT];
        end
      end
      r_d_rdy <= bus.d_req;
      if (bus.d_req) begin
        r_d_miss <= !w_d_hit;
        if (!w_d_hit) begin
          r_d_paddr <= '0;
          r_d_v     <= 1'b0;
          r_d_dirty <= 1'b0;
        end else if (bus.d_vaddr[12]) begin
          r_d_paddr <= tlb_paddr(w_d_ent[PFN1_LO +: 20], bus.d_vaddr[11:0]);
          r_d_v     <= w_d_ent[V1_BIT];
          r_d_dirty <= w_d_ent[D1_BIT];
        end else begin
          r_d_paddr <= tlb_paddr(w_d_ent[PFN0_LO +: 20], bus.d_vaddr[11:0]);
          r_d_v     <= w_d_ent[V0_BIT];
          r_d_dirty <= w_d_ent[D0_BIT];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_done  <= 1'b0;
      r_rd_entry <= '0;
      r_probe    <= 32'h8000_0000;
      r_multi    <= 1'b0;
    end else begin
      r_op_done <= w_we || w_is_p || w_is_r;
      if (w_is_r) r_rd_entry <= r_present[bus.op_index] ? r_entry[bus.op_index] : '0;
      if (w_is_p) begin
        r_probe <= '0;
        if (w_p_hit) r_probe[IDX_W-1:0] <= w_p_idx;
        else         r_probe[PROBE_MISS_BIT] <= 1'b1;
      end
      r_multi <= r_multi || (bus.i_req && w_i_multi) || (bus.d_req && w_d_multi) ||
                 (w_is_p && w_p_multi);
    end
  end

  assign bus.i_rdy     = r_i_rdy;
  assign bus.i_paddr   = r_i_paddr;
  assign bus.i_miss    = r_i_miss;
  assign bus.i_v       = r_i_v;
  assign bus.d_rdy     = r_d_rdy;
  assign bus.d_paddr   = r_d_paddr;
  assign bus.d_miss    = r_d_miss;
  assign bus.d_v       = r_d_v;
  assign bus.d_dirty   = r_d_dirty;
  assign bus.op_done   = r_op_done;
  assign bus.rd_entry  = r_rd_entry;
  assign bus.probe     = r_probe;
  assign bus.random    = r_random;
  assign bus.multi_hit = r_multi;

endmodule
